// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage between EX/MEM and mem_wb_reg.
// Runs one load/store at a time over a valid/ready data bus.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_w_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [XLEN-1:0]   in_exu_result,
    input  logic [XLEN-1:0]   in_x_rs2,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [4:0]        out_rd,
    output logic              out_rd_w_en,
    output logic [XLEN-1:0]   out_exu_result,
    output logic [XLEN-1:0]   out_lsu_r_data,
    output logic              out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q;
    logic [31:0]       pc_q;
    logic [31:0]       inst_q;
    logic [4:0]        rd_q;
    logic              rd_w_en_q;
    logic [XLEN-1:0]   exu_q;
    logic [XLEN-1:0]   lsu_q;
    logic              mis_q;
    logic              load_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              req_wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic [7:0]        wmask_q;

    logic              accept;
    logic              is_mem_d;
    logic              mis_d;
    logic [2:0]        off_d;
    logic [7:0]        base_mask;
    logic [7:0]        wmask_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   ld_shift;
    logic              ld_sext;
    logic [XLEN-1:0]   lsu_d;

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign is_mem_d = in_mem_r_en | in_mem_w_en;
    assign off_d    = in_exu_result[2:0];

    // Alignment check and byte-lane strobe base for the incoming access size
    always_comb begin
        mis_d     = 1'b0;
        base_mask = 8'h01;
        unique case (in_inst[13:12])
            2'd0: begin mis_d = 1'b0;         base_mask = 8'h01; end
            2'd1: begin mis_d = off_d[0];     base_mask = 8'h03; end
            2'd2: begin mis_d = |off_d[1:0];  base_mask = 8'h0F; end
            2'd3: begin mis_d = |off_d;       base_mask = 8'hFF; end
        endcase
        mis_d = mis_d & is_mem_d;
    end

    assign wmask_d = base_mask << off_d;
    assign wdata_d = in_x_rs2 << {off_d, 3'b000};

    assign ld_shift = mem_rdata >> {exu_q[2:0], 3'b000};
    assign ld_sext  = ~inst_q[14];

    // Truncate the lane-shifted read word and sign/zero extend it
    always_comb begin
        lsu_d = ld_shift;
        unique case (inst_q[13:12])
            2'd0: lsu_d = {{(XLEN-8){ld_sext & ld_shift[7]}}, ld_shift[7:0]};
            2'd1: lsu_d = {{(XLEN-16){ld_sext & ld_shift[15]}}, ld_shift[15:0]};
            2'd2: lsu_d = {{(XLEN-32){ld_sext & ld_shift[31]}}, ld_shift[31:0]};
            2'd3: lsu_d = ld_shift;
        endcase
    end

    // Stage FSM: latch on accept, run the bus request, hold the result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inst_q     <= '0;
            rd_q       <= '0;
            rd_w_en_q  <= 1'b0;
            exu_q      <= '0;
            lsu_q      <= '0;
            mis_q      <= 1'b0;
            load_q     <= 1'b0;
            req_addr_q <= '0;
            req_wen_q  <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (accept) begin
            pc_q       <= in_pc;
            inst_q     <= in_inst;
            rd_q       <= in_rd;
            rd_w_en_q  <= in_rd_w_en & ~mis_d;
            exu_q      <= in_exu_result;
            lsu_q      <= '0;
            mis_q      <= mis_d;
            load_q     <= in_mem_r_en;
            req_addr_q <= {in_exu_result[ADDR_W-1:3], 3'b000};
            req_wen_q  <= in_mem_w_en;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            state_q    <= (is_mem_d & ~mis_d) ? REQ : DONE;
        end else begin
            unique case (state_q)
                IDLE: state_q <= IDLE;
                REQ: begin
                    if (mem_req_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (load_q) lsu_q <= lsu_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = req_addr_q;
    assign mem_req_wen    = req_wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign out_valid      = (state_q == DONE);
    assign out_pc         = pc_q;
    assign out_inst       = inst_q;
    assign out_rd         = rd_q;
    assign out_rd_w_en    = rd_w_en_q;
    assign out_exu_result = exu_q;
    assign out_lsu_r_data = lsu_q;
    assign out_misalign   = mis_q;

endmodule
